// File: rtl/jstk_pkg.sv
// Shared definitions for the joystick SPI reader: FSM encoding, frame layout,
// direction bit positions and the centred axis value used at reset.
package jstk_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_XFER,
    ST_GAP,
    ST_POST,
    ST_DONE
  } state_t;

  localparam int FRAME_BYTES = 5;

  localparam int POS_UP    = 0;
  localparam int POS_DOWN  = 1;
  localparam int POS_LEFT  = 2;
  localparam int POS_RIGHT = 3;

  localparam logic [9:0] AXIS_CENTER = 10'd512;
endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 single-byte receive engine: 8 SCLK periods, MSB first,
// miso captured on the cycle sclk rises, done on the cycle of the 8th fall.
module spi_byte_shifter #(
  parameter int SCLK_HALF = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       miso,
  output logic       sclk,
  output logic       done,
  output logic [7:0] rx_byte
);
  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCLK_HALF - 1);

  logic          active;
  logic [CW-1:0] cnt;
  logic [2:0]    nfall;
  logic          half_end;

  assign half_end = active && (cnt == CNT_LAST);
  // Combinational so the caller moves on in the same edge as the last fall,
  // keeping each byte exactly 16 half-periods long.
  assign done = half_end && sclk && (nfall == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      cnt     <= '0;
      nfall   <= '0;
      sclk    <= 1'b0;
      rx_byte <= '0;
    end else if (!active) begin
      if (start) begin
        active <= 1'b1;
        cnt    <= '0;
        nfall  <= '0;
      end
    end else if (half_end) begin
      cnt  <= '0;
      sclk <= ~sclk;
      if (!sclk) begin
        rx_byte <= {rx_byte[6:0], miso};
      end else begin
        nfall <= nfall + 3'd1;
        if (nfall == 3'd7) active <= 1'b0;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/jstk_spi_reader.sv
// Polls the joystick over SPI mode 0, assembles the 5-byte status frame and
// decodes axis thresholds into the direction vector and button level.
module jstk_spi_reader
  import jstk_pkg::*;
#(
  parameter int SCLK_HALF = 50,
  parameter int PRE_DLY   = 1500,
  parameter int BYTE_DLY  = 1000,
  parameter int POST_DLY  = 2500,
  parameter int POLL_GAP  = 1_000_000,
  parameter int LOW_TH    = 256,
  parameter int HIGH_TH   = 768
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       cs_n,
  output logic [3:0] jstkPos,
  output logic       jstkPress,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       valid,
  output logic       busy
);
  localparam int DMAX = (PRE_DLY > BYTE_DLY) ?
                        ((PRE_DLY > POST_DLY) ? PRE_DLY : POST_DLY) :
                        ((BYTE_DLY > POST_DLY) ? BYTE_DLY : POST_DLY);
  localparam int DW = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam int GW = $clog2(POLL_GAP + 1);

  localparam logic [DW-1:0] PRE_LAST  = DW'(PRE_DLY - 1);
  localparam logic [DW-1:0] BYTE_LAST = DW'(BYTE_DLY - 1);
  localparam logic [DW-1:0] POST_LAST = DW'(POST_DLY - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP);
  localparam logic [2:0]    LAST_BYTE = 3'(FRAME_BYTES - 1);
  localparam logic [9:0]    LO        = 10'(LOW_TH);
  localparam logic [9:0]    HI        = 10'(HIGH_TH);

  state_t        state;
  logic [GW-1:0] gap;
  logic [DW-1:0] dly;
  logic [2:0]    bidx;
  logic [9:0]    xn, yn;
  logic          btn;
  logic          start, done;
  logic [7:0]    rx_byte;
  logic [3:0]    pos_next;

  assign mosi = 1'b0;
  assign busy = ~cs_n;

  // Start is issued on the edge that leaves PRE/GAP so no cycle is lost
  // between the delay expiring and the first SCLK half-period.
  assign start = ((state == ST_PRE) && (dly == PRE_LAST)) ||
                 ((state == ST_GAP) && (dly == BYTE_LAST));

  spi_byte_shifter #(.SCLK_HALF(SCLK_HALF)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .miso    (miso),
    .sclk    (sclk),
    .done    (done),
    .rx_byte (rx_byte)
  );

  always_comb begin
    pos_next            = '0;
    pos_next[POS_UP]    = (yn > HI);
    pos_next[POS_DOWN]  = (yn < LO);
    pos_next[POS_LEFT]  = (xn < LO);
    pos_next[POS_RIGHT] = (xn > HI);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gap       <= '0;
      dly       <= '0;
      bidx      <= '0;
      xn        <= AXIS_CENTER;
      yn        <= AXIS_CENTER;
      btn       <= 1'b0;
      cs_n      <= 1'b1;
      x         <= AXIS_CENTER;
      y         <= AXIS_CENTER;
      jstkPos   <= '0;
      jstkPress <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gap != GAP_LAST) begin
            gap <= gap + 1'b1;
          end else if (en) begin
            state <= ST_PRE;
            cs_n  <= 1'b0;
            dly   <= '0;
          end
        end
        ST_PRE: begin
          if (dly == PRE_LAST) begin
            state <= ST_XFER;
            bidx  <= '0;
          end else begin
            dly <= dly + 1'b1;
          end
        end
        ST_XFER: begin
          if (done) begin
            case (bidx)
              3'd0:    xn[7:0] <= rx_byte;
              3'd1:    xn[9:8] <= rx_byte[1:0];
              3'd2:    yn[7:0] <= rx_byte;
              3'd3:    yn[9:8] <= rx_byte[1:0];
              default: btn     <= rx_byte[0];
            endcase
            bidx  <= bidx + 3'd1;
            dly   <= '0;
            state <= (bidx == LAST_BYTE) ? ST_POST : ST_GAP;
          end
        end
        ST_GAP: begin
          if (dly == BYTE_LAST) state <= ST_XFER;
          else                  dly   <= dly + 1'b1;
        end
        ST_POST: begin
          if (dly == POST_LAST) begin
            state     <= ST_DONE;
            cs_n      <= 1'b1;
            x         <= xn;
            y         <= yn;
            jstkPos   <= pos_next;
            jstkPress <= btn;
            valid     <= 1'b1;
          end else begin
            dly <= dly + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          gap   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jstk_spi_reader.sv
// Directed bench for jstk_spi_reader with a bit-serial joystick model and a
// protocol monitor running on the falling clock edge.
module tb_jstk_spi_reader;
  localparam int H = 2, PRE = 4, BYTE = 3, POST = 5, GAP = 10;
  localparam int FLEN = PRE + 80 * H + 4 * BYTE + POST;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, miso = 1'b0;
  logic sclk, mosi, cs_n, jstkPress, valid, busy;
  logic [3:0] jstkPos;
  logic [9:0] x, y;

  always #5 clk = ~clk;

  jstk_spi_reader #(
    .SCLK_HALF(H), .PRE_DLY(PRE), .BYTE_DLY(BYTE), .POST_DLY(POST),
    .POLL_GAP(GAP), .LOW_TH(256), .HIGH_TH(768)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .miso(miso), .sclk(sclk), .mosi(mosi),
    .cs_n(cs_n), .jstkPos(jstkPos), .jstkPress(jstkPress), .x(x), .y(y),
    .valid(valid), .busy(busy)
  );

  int n_checks = 0, n_fail = 0;
  logic [39:0] fbits = '0;
  int idx = 40, rises = 0, low_cnt = 0, last_len = 0, falls = 0;
  int sclk_viol = 0, mosi_viol = 0, busy_viol = 0, valid_viol = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;

  // Slave model: next bit presented at cs_n fall and after every sclk fall.
  always @(negedge clk) begin
    if (cs_n === 1'b0) begin
      if (prev_cs) begin
        idx = 0; rises = 0; low_cnt = 0; falls++;
      end
      low_cnt++;
      if (prev_sclk && !sclk) idx++;
      if (!prev_sclk && sclk) rises++;
    end else begin
      if (!prev_cs) last_len = low_cnt;
      if (sclk === 1'b1) sclk_viol++;
    end
    if (mosi !== 1'b0 && !rst) mosi_viol++;
    if (busy !== ~cs_n) busy_viol++;
    if (valid === 1'b1 && !(cs_n === 1'b1 && prev_cs === 1'b0)) valid_viol++;
    miso = (idx < 40) ? fbits[39-idx] : 1'b0;
    prev_cs = cs_n;
    prev_sclk = sclk;
  end

  task automatic frame(input logic [7:0] b0, b1, b2, b3, b4, output bit ok);
    fbits = {b0, b1, b2, b3, b4};
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1; en = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
    n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    n_checks++; if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    n_checks++; if (x !== 10'd512 || y !== 10'd512) begin n_fail++; $display("FAIL reset_xy: got %0d,%0d want 512,512", x, y); end
    n_checks++; if (jstkPos !== 4'b0 || jstkPress !== 1'b0) begin n_fail++; $display("FAIL reset_pos: got %b,%b want 0000,0", jstkPos, jstkPress); end
    n_checks++; if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_valid_busy: got %b,%b want 0,0", valid, busy); end
    rst = 0;
  endtask

  task automatic test_basic;
    bit ok;
    en = 1;
    frame(8'hFF, 8'h03, 8'h00, 8'h02, 8'h01, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: no valid within budget"); end
    n_checks++; if (x !== 10'd1023 || y !== 10'd512) begin n_fail++; $display("FAIL basic_xy: got %0d,%0d want 1023,512", x, y); end
    n_checks++; if (jstkPos !== 4'b1000) begin n_fail++; $display("FAIL basic_pos: got %b want 1000", jstkPos); end
    n_checks++; if (jstkPress !== 1'b1) begin n_fail++; $display("FAIL basic_press: got %b want 1", jstkPress); end
    n_checks++; if (cs_n !== 1'b1) begin n_fail++; $display("FAIL basic_cs_with_valid: got %b want 1", cs_n); end
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_width: got %b want 0", valid); end
    n_checks++; if (rises != 40) begin n_fail++; $display("FAIL basic_rises: got %0d want 40", rises); end
    n_checks++; if (last_len != FLEN) begin n_fail++; $display("FAIL basic_len: got %0d want %0d", last_len, FLEN); end
    n_checks++; if (x !== 10'd1023 || jstkPress !== 1'b1) begin n_fail++; $display("FAIL basic_hold: got %0d,%b want 1023,1", x, jstkPress); end
  endtask

  task automatic test_center_pair;
    bit ok;
    frame(8'h00, 8'h02, 8'h00, 8'h02, 8'h00, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL center_timeout: no valid within budget"); end
    n_checks++; if (jstkPos !== 4'b0000 || jstkPress !== 1'b0) begin n_fail++; $display("FAIL center_pos: got %b,%b want 0000,0", jstkPos, jstkPress); end
    n_checks++; if (x !== 10'd512) begin n_fail++; $display("FAIL center_x: got %0d want 512", x); end
    frame(8'h00, 8'h00, 8'hFF, 8'h03, 8'h00, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL upleft_timeout: no valid within budget"); end
    n_checks++; if (jstkPos !== 4'b0101) begin n_fail++; $display("FAIL upleft_pos: got %b want 0101", jstkPos); end
    n_checks++; if (x !== 10'd0 || y !== 10'd1023) begin n_fail++; $display("FAIL upleft_xy: got %0d,%0d want 0,1023", x, y); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    fbits = {8'h00, 8'h03, 8'h00, 8'h02, 8'h00};
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0 && idx == 19) begin ok = 1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_reach: byte 2 bit 3 not reached"); end
    rst = 1;
    @(posedge clk); #1;
    n_checks++; if (cs_n !== 1'b1 || sclk !== 1'b0) begin n_fail++; $display("FAIL rstmid_pins: got cs_n=%b sclk=%b want 1,0", cs_n, sclk); end
    n_checks++; if (x !== 10'd512 || y !== 10'd512 || jstkPos !== 4'b0) begin n_fail++; $display("FAIL rstmid_out: got %0d,%0d,%b want 512,512,0000", x, y, jstkPos); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", valid); end
    @(negedge clk); rst = 0;
    frame(8'h00, 8'h03, 8'h00, 8'h02, 8'h00, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL x768_timeout: no valid within budget"); end
    n_checks++; if (x !== 10'd768 || jstkPos[3] !== 1'b0) begin n_fail++; $display("FAIL x768: got x=%0d right=%b want 768,0", x, jstkPos[3]); end
    @(negedge clk);
    n_checks++; if (rises != 40 || last_len != FLEN) begin n_fail++; $display("FAIL rstmid_full: got rises=%0d len=%0d want 40,%0d", rises, last_len, FLEN); end
  endtask

  task automatic test_thresholds;
    bit ok;
    frame(8'h01, 8'h03, 8'h00, 8'h02, 8'h00, ok);
    n_checks++; if (!ok || x !== 10'd769 || jstkPos !== 4'b1000) begin n_fail++; $display("FAIL x769: got ok=%b x=%0d pos=%b want 1,769,1000", ok, x, jstkPos); end
    frame(8'h00, 8'h02, 8'h00, 8'h01, 8'h00, ok);
    n_checks++; if (!ok || y !== 10'd256 || jstkPos !== 4'b0000) begin n_fail++; $display("FAIL y256: got ok=%b y=%0d pos=%b want 1,256,0000", ok, y, jstkPos); end
    frame(8'h00, 8'h02, 8'hFF, 8'h00, 8'h00, ok);
    n_checks++; if (!ok || y !== 10'd255 || jstkPos !== 4'b0010) begin n_fail++; $display("FAIL y255: got ok=%b y=%0d pos=%b want 1,255,0010", ok, y, jstkPos); end
  endtask

  task automatic test_en_off;
    int f0;
    rst = 1; en = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    f0 = falls;
    repeat (300) @(negedge clk);
    n_checks++; if (falls != f0 || cs_n !== 1'b1) begin n_fail++; $display("FAIL en_off: got falls=%0d cs_n=%b want %0d,1", falls, cs_n, f0); end
  endtask

  task automatic test_en_drop;
    bit ok;
    int f0;
    fbits = {8'hFF, 8'h03, 8'hFF, 8'h03, 8'h01};
    en = 1;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (cs_n === 1'b0 && idx == 10) begin ok = 1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL en_drop_reach: byte 1 not reached"); end
    en = 0;
    frame(8'hFF, 8'h03, 8'hFF, 8'h03, 8'h01, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL en_drop_timeout: frame did not complete"); end
    n_checks++; if (x !== 10'd1023 || y !== 10'd1023 || jstkPos !== 4'b1001 || jstkPress !== 1'b1) begin
      n_fail++; $display("FAIL en_drop_out: got %0d,%0d,%b,%b want 1023,1023,1001,1", x, y, jstkPos, jstkPress); end
    f0 = falls;
    repeat (300) @(negedge clk);
    n_checks++; if (falls != f0 || cs_n !== 1'b1) begin n_fail++; $display("FAIL en_drop_stop: got falls=%0d cs_n=%b want %0d,1", falls, cs_n, f0); end
  endtask

  task automatic test_protocol;
    n_checks++; if (sclk_viol != 0) begin n_fail++; $display("FAIL sclk_idle: got %0d events want 0", sclk_viol); end
    n_checks++; if (mosi_viol != 0) begin n_fail++; $display("FAIL mosi_zero: got %0d events want 0", mosi_viol); end
    n_checks++; if (busy_viol != 0) begin n_fail++; $display("FAIL busy_eq: got %0d events want 0", busy_viol); end
    n_checks++; if (valid_viol != 0) begin n_fail++; $display("FAIL valid_align: got %0d events want 0", valid_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_center_pair();
    test_reset_mid();
    test_thresholds();
    test_en_off();
    test_en_drop();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
